// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM array controller and its row storage.
package sram_pkg;

    // Controller mode: CLEAR walks every row writing zeros, READY serves requests.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_e;

    // Default geometry of the storage block.
    localparam int DEF_ROWS   = 64;
    localparam int DEF_COLS   = 64;
    localparam int DEF_MASK_W = 8;

    // Number of write-mask lanes in the default geometry.
    localparam int LANES = DEF_COLS / DEF_MASK_W;

    // Lane count for an arbitrary geometry; used to size mask ports.
    function automatic int lanes_of(input int cols, input int mask_w);
        return cols / mask_w;
    endfunction

endpackage

// File: rtl/sram_row.sv
// One storage row: lane-masked synchronous write, combinational read.
// Contents are not reset; the controller's clear engine zeroes them.
module sram_row
    import sram_pkg::*;
#(
    parameter int  COLS   = DEF_COLS,
    parameter int  MASK_W = DEF_MASK_W,
    localparam int LN     = lanes_of(COLS, MASK_W)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [LN-1:0]   wmask_i,
    input  logic [COLS-1:0] wdata_i,
    output logic [COLS-1:0] rdata_o
);

    logic [COLS-1:0] data_q;

    // Update only the lanes whose mask bit is set; the others hold.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LN; i++) begin
            if (we_i && wmask_i[i]) begin
                data_q[i*MASK_W +: MASK_W] <= wdata_i[i*MASK_W +: MASK_W];
            end
        end
    end

    assign rdata_o = data_q;

endmodule

// File: rtl/sram_array_ctrl.sv
// SRAM array controller: valid/ready request port, lane-masked writes,
// registered read response with backpressure, and a row-by-row clear engine
// that runs after reset and on a clr pulse.
module sram_array_ctrl
    import sram_pkg::*;
#(
    parameter int  ROWS   = DEF_ROWS,
    parameter int  COLS   = DEF_COLS,
    parameter int  MASK_W = DEF_MASK_W,
    localparam int LN     = lanes_of(COLS, MASK_W),
    localparam int AW     = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    output logic            busy,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [LN-1:0]   req_wmask,
    input  logic [COLS-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [COLS-1:0] rsp_rdata
);

    sram_state_e     state_q;
    logic [AW-1:0]   cnt_q;
    logic            busy_q;

    logic            rsp_valid_q, rsp_valid_d;
    logic [COLS-1:0] rsp_rdata_q, rsp_rdata_d;

    logic            ready_w;
    logic            rd_accept_w;
    logic            wr_accept_w;
    logic            clear_mode_w;
    logic [LN-1:0]   row_mask_w;
    logic [COLS-1:0] row_wdata_w;
    logic [COLS-1:0] row_rdata [ROWS];
    logic [COLS-1:0] rd_word_w;

    // A request can be taken only when serving and the response slot is free
    // or being emptied this cycle, so at most one response is outstanding.
    assign ready_w     = (state_q == READY) && (!rsp_valid_q || rsp_ready);
    assign rd_accept_w = req_valid && ready_w && !req_we;
    assign wr_accept_w = req_valid && ready_w && req_we;

    // While clearing, every row write is a full-width write of zeros.
    assign clear_mode_w = (state_q == CLEAR);
    assign row_mask_w   = clear_mode_w ? {LN{1'b1}} : req_wmask;
    assign row_wdata_w  = clear_mode_w ? '0 : req_wdata;

    // Row decoder and storage: one row instance per address.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic row_we;

            // Select this row for the clear sweep or for an accepted write.
            always_comb begin
                row_we = 1'b0;
                if (clear_mode_w) begin
                    row_we = (cnt_q == AW'(gi));
                end else begin
                    row_we = wr_accept_w && (req_addr == AW'(gi));
                end
            end

            sram_row #(
                .COLS   (COLS),
                .MASK_W (MASK_W)
            ) u_row (
                .clk     (clk),
                .we_i    (row_we),
                .wmask_i (row_mask_w),
                .wdata_i (row_wdata_w),
                .rdata_o (row_rdata[gi])
            );
        end
    endgenerate

    // Read mux: the addressed row feeds the response register.
    assign rd_word_w = row_rdata[req_addr];

    // Clear engine FSM: sweep rows 0..ROWS-1, then serve; clr restarts the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (cnt_q == AW'(ROWS - 1)) begin
                        state_q <= READY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                READY: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Response slot next state: a new read refills it, a handshake empties it,
    // and the data holds otherwise so it stays stable under backpressure.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        if (rd_accept_w) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_word_w;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register; independent of the clear engine so a pending
    // response can still complete while the array is being cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign busy      = busy_q;
    assign req_ready = ready_w;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
